div_seq_unit: RTL and testbench
===============================

// Module: div_seq_unit
// PURPOSE
//  Multicycle signed integer divider. It is the responder to the CPU control unit's divide request.
//  - On a DivCtrl start it computes A/B over WIDTH+1 cycles.
//  - It returns quotient (to LO) and remainder (to HI) with a one-cycle done pulse.
//  - It flags divide-by-zero so the control unit can enter the exception path.
//  - It sits beside the HI/LO muxes; operands come from the A and B registers.
// PARAMETERS
//  WIDTH  32  operand/result width; iteration count equals WIDTH
// PORTS
//  clk        in   1      system clock, rising edge
//  reset      in   1      synchronous, active-low reset (0 = reset)
//  div_start  in   1      start request (DivCtrl); sampled in IDLE only
//  dividend   in   WIDTH  A register value, sampled on accepted start
//  divisor    in   WIDTH  B register value, sampled on accepted start
//  busy       out  1      high in RUN and FIX states
//  done       out  1      one-cycle pulse; hi_out/lo_out valid from this cycle on
//  div_zero   out  1      one-cycle pulse; divisor was 0, no result produced
//  hi_out     out  WIDTH  remainder; held until the next completed divide
//  lo_out     out  WIDTH  quotient; held until the next completed divide
// BEHAVIOUR
//  - Reset (reset==0 at an edge): state=IDLE; busy, done, div_zero = 0; hi_out, lo_out = 0.
//  - Reset has priority over everything, including mid-RUN; any partial result is discarded.
//  - States: IDLE, RUN, FIX, DZ.
//  - IDLE with div_start=1, divisor!=0:
//    - latch |dividend| and |divisor|, and the signs of dividend and of dividend^divisor.
//    - clear the remainder accumulator and the iteration counter; go to RUN.
//  - IDLE with div_start=1, divisor==0: go to DZ. In DZ, div_zero=1 for one cycle, then IDLE.
//    hi_out and lo_out are unchanged.
//  - RUN: one restoring step per cycle, MSB first:
//    - rem = {rem, q[MSB]}; if rem >= |divisor|, subtract it and shift in 1, else shift in 0.
//    - Use a WIDTH+1-bit compare/subtract.
//    - After WIDTH steps go to FIX (the counter runs 0..WIDTH-1).
//  - FIX:
//    - lo_out = quotient, negated if the operand signs differ.
//    - hi_out = remainder, negated if the dividend is negative.
//    - done=1 in the following cycle; return to IDLE.
//  - Latency: start accepted at edge E0; results and done are registered at edge E(WIDTH+1).
//    For WIDTH=32: done is high for exactly the cycle after edge E33.
//  - Semantics follow MIPS DIV:
//    - the quotient truncates toward zero; the remainder takes the sign of the dividend.
//    - |dividend| is computed in WIDTH+1 bits so that INT_MIN is exact.
//  - INT_MIN / -1: lo_out=0x80000000 (wraps), hi_out=0, done normal. No overflow flag.
//  - div_start while busy, in FIX or in DZ: ignored, not queued.
//  - Operand inputs may change after E0 without effect.
//  - div_start held high across done: a new divide is accepted on the first IDLE cycle.
//    This is the cycle done is high, so a back-to-back divide is one cycle after done.
//  - done and div_zero are never high in the same cycle.
//  - busy=1 from the cycle after E0 through the FIX cycle. busy=0 in DZ.
// CONFIGURATION
//  DIV_UNSIGNED_EN:
//    - When defined, adds input port div_unsigned (1 bit), sampled with div_start.
//    - When div_unsigned=1, operands are used raw and no sign fix-up is applied in FIX (DIVU).
//      Latency is unchanged.
//  Without DIV_UNSIGNED_EN:
//    - The port is absent and every divide is signed.
// TESTING
//  1. 100 / 7: after 33 cycles, done=1, lo_out=14, hi_out=2. busy=0 the cycle after done.
//  2. -100 / 7: lo_out=0xFFFFFFF2 (-14), hi_out=0xFFFFFFFE (-2).
//     100 / -7: lo_out=-14, hi_out=2.
//  3. 5 / 0: div_zero=1 exactly one cycle after start, done never rises.
//     hi_out/lo_out keep the previous result. Next start is accepted normally.
//  4. 0x80000000 / 0xFFFFFFFF: lo_out=0x80000000, hi_out=0.
//     0x80000000 / 1: lo_out=0x80000000, hi_out=0.
//  5. Start 1000/3, pulse start again at cycle 10 (ignored), drive reset=0 at cycle 20:
//     all outputs 0, done never rises. Restart gives lo_out=333, hi_out=1.
//  6. DIV_UNSIGNED_EN, div_unsigned=1, 0xFFFFFFFF / 2: lo_out=0x7FFFFFFF, hi_out=1.
//     The same operands with div_unsigned=0 give lo_out=0, hi_out=0xFFFFFFFF.

Source files
------------

// File: rtl/div_seq_unit.sv
// ---------------------------------------------------------------------------
// div_seq_unit
// Multicycle signed integer divider serving the CPU control unit's divide
// request. One restoring step per cycle, MSB first, followed by a sign
// fix-up cycle. The quotient goes to LO and the remainder goes to HI. The
// semantics match MIPS DIV: the quotient truncates toward zero, the remainder
// takes the sign of the dividend, and INT_MIN / -1 wraps to INT_MIN.
//
// Ports
//   clk          system clock, rising edge
//   reset        synchronous, active-low reset (0 = reset)
//   div_start    start request, sampled in IDLE only
//   div_unsigned (DIV_UNSIGNED_EN only) 1 = DIVU, sampled with div_start
//   dividend     A register value, sampled on accepted start
//   divisor      B register value, sampled on accepted start
//   busy         high in RUN and FIX
//   done         one-cycle pulse; hi_out/lo_out are valid from this cycle on
//   div_zero     one-cycle pulse; divisor was zero and no result is produced
//   hi_out       remainder, held until the next completed divide
//   lo_out       quotient, held until the next completed divide
//
// Configuration
//   DIV_UNSIGNED_EN  when defined, adds the div_unsigned port for DIVU.
//                    When it is not defined, every divide is signed.
// ---------------------------------------------------------------------------
module div_seq_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             div_start,
`ifdef DIV_UNSIGNED_EN
  input  logic             div_unsigned,
`endif
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DZ   = 2'd3
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvs;
  logic [CW-1:0]    count;
  logic             neg_q;
  logic             neg_r;

  logic             use_signed;
  logic             sign_a;
  logic             sign_b;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic [WIDTH:0]   shifted;
  logic             step_ge;
  logic [WIDTH-1:0] rem_next;

  // Operand conditioning. The magnitude of INT_MIN (2^(WIDTH-1)) fits
  // exactly in the WIDTH-bit unsigned magnitude register. This is why the
  // two's-complement negate below is exact for every signed input.
  always_comb begin
    use_signed = 1'b1;
`ifdef DIV_UNSIGNED_EN
    use_signed = !div_unsigned;
`endif
    sign_a = use_signed & dividend[WIDTH-1];
    sign_b = use_signed & divisor[WIDTH-1];
    abs_a  = sign_a ? -dividend : dividend;
    abs_b  = sign_b ? -divisor  : divisor;
  end

  // One restoring step. The partial remainder and the next quotient bit
  // form a WIDTH+1-bit value, so the compare never overflows even when the
  // divisor uses its full WIDTH bits.
  always_comb begin
    shifted  = {rem, quo[WIDTH-1]};
    step_ge  = shifted >= {1'b0, dvs};
    rem_next = step_ge ? (shifted[WIDTH-1:0] - dvs) : shifted[WIDTH-1:0];
  end

  // Next-state and Moore outputs. A start request is only looked at in
  // IDLE, so requests made while busy are dropped rather than queued.
  always_comb begin
    state_d  = state_q;
    busy     = 1'b0;
    div_zero = 1'b0;
    case (state_q)
      IDLE: begin
        if (div_start) begin
          state_d = (divisor == '0) ? DZ : RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (count == CW'(WIDTH - 1)) begin
          state_d = FIX;
        end
      end
      FIX: begin
        busy    = 1'b1;
        state_d = IDLE;
      end
      DZ: begin
        div_zero = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register and datapath. Reset wins over everything, so a divide
  // that is in flight is abandoned and the result registers are cleared.
  // The result registers load only in FIX. A divide-by-zero leaves the
  // previous result visible.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      rem     <= '0;
      quo     <= '0;
      dvs     <= '0;
      count   <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      done    <= 1'b0;
      hi_out  <= '0;
      lo_out  <= '0;
    end else begin
      state_q <= state_d;
      done    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (div_start && (divisor != '0)) begin
            quo   <= abs_a;
            dvs   <= abs_b;
            neg_r <= sign_a;
            neg_q <= sign_a ^ sign_b;
            rem   <= '0;
            count <= '0;
          end
        end
        RUN: begin
          rem   <= rem_next;
          quo   <= {quo[WIDTH-2:0], step_ge};
          count <= count + CW'(1);
        end
        FIX: begin
          lo_out <= neg_q ? -quo : quo;
          hi_out <= neg_r ? -rem : rem;
          done   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq_unit.sv
// ---------------------------------------------------------------------------
// tb_div_seq_unit
// Directed self-checking bench for div_seq_unit with WIDTH = 32. Expected
// quotients and remainders are hand-computed MIPS DIV results. Inputs change
// and outputs are sampled 1 ns after each rising edge.
// ---------------------------------------------------------------------------
module tb_div_seq_unit;

  logic        clk;
  logic        reset;
  logic        div_start;
`ifdef DIV_UNSIGNED_EN
  logic        div_unsigned;
`endif
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi_out;
  logic [31:0] lo_out;

  int checks = 0;
  int errors = 0;

  div_seq_unit #(.WIDTH(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .div_start    (div_start),
`ifdef DIV_UNSIGNED_EN
    .div_unsigned (div_unsigned),
`endif
    .dividend     (dividend),
    .divisor      (divisor),
    .busy         (busy),
    .done         (done),
    .div_zero     (div_zero),
    .hi_out       (hi_out),
    .lo_out       (lo_out)
  );

  // Free-running 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Advance one clock and settle 1 ns past the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle start pulse; returns 1 ns after the accepting edge E0
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b);
    dividend  = a;
    divisor   = b;
    div_start = 1'b1;
    tick();
    div_start = 1'b0;
  endtask

  // Bounded wait for done; reports the number of edges after E0
  task automatic waitDone(output int cycles);
    cycles = 0;
    while (!done && cycles < 100) begin
      tick();
      cycles++;
    end
  endtask

  // Full divide: latency, results, busy low on the done cycle, single pulse
  task automatic divideCheck(input string tag, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] exp_lo, input logic [31:0] exp_hi);
    int cycles;
    applyStimulus(a, b);
    waitDone(cycles);
    checkOutput({tag, "_latency"}, cycles, 32'd33);
    checkOutput({tag, "_lo"}, lo_out, exp_lo);
    checkOutput({tag, "_hi"}, hi_out, exp_hi);
    checkOutput({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
    tick();
    checkOutput({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
  endtask

  // Watch n cycles and report whether done was ever seen
  task automatic watchNoDone(input int n, output logic seen);
    seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (done) seen = 1'b1;
    end
  endtask

  initial begin
    int   cycles;
    logic seen;

    reset     = 1'b0;
    div_start = 1'b0;
    dividend  = '0;
    divisor   = '0;
`ifdef DIV_UNSIGNED_EN
    div_unsigned = 1'b0;
`endif
    tick();
    tick();
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_done", {31'd0, done}, 32'd0);
    checkOutput("reset_dz", {31'd0, div_zero}, 32'd0);
    checkOutput("reset_hi", hi_out, 32'd0);
    checkOutput("reset_lo", lo_out, 32'd0);
    reset = 1'b1;
    tick();

    $display("[TB] basic signed divides");
    applyStimulus(32'd100, 32'd7);
    checkOutput("p100_busy_after_e0", {31'd0, busy}, 32'd1);
    waitDone(cycles);
    checkOutput("p100_latency", cycles, 32'd33);
    checkOutput("p100_lo", lo_out, 32'd14);
    checkOutput("p100_hi", hi_out, 32'd2);
    tick();
    checkOutput("p100_busy_after", {31'd0, busy}, 32'd0);
    checkOutput("p100_done_pulse", {31'd0, done}, 32'd0);

    divideCheck("n100_p7", 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE);
    divideCheck("p100_n7", 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 32'd2);
    divideCheck("n100_n7", 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 32'hFFFF_FFFE);

    $display("[TB] divide by zero");
    applyStimulus(32'd5, 32'd0);
    checkOutput("dz_pulse", {31'd0, div_zero}, 32'd1);
    checkOutput("dz_busy", {31'd0, busy}, 32'd0);
    checkOutput("dz_done", {31'd0, done}, 32'd0);
    tick();
    checkOutput("dz_single_pulse", {31'd0, div_zero}, 32'd0);
    watchNoDone(40, seen);
    checkOutput("dz_no_done", {31'd0, seen}, 32'd0);
    checkOutput("dz_lo_kept", lo_out, 32'd14);
    checkOutput("dz_hi_kept", hi_out, 32'hFFFF_FFFE);
    divideCheck("after_dz", 32'd7, 32'd2, 32'd3, 32'd1);

    $display("[TB] INT_MIN corner cases");
    divideCheck("min_neg1", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0);
    divideCheck("min_p1", 32'h8000_0000, 32'd1, 32'h8000_0000, 32'd0);
    divideCheck("neg1_p2", 32'hFFFF_FFFF, 32'd2, 32'd0, 32'hFFFF_FFFF);
    divideCheck("p7_min", 32'd7, 32'h8000_0000, 32'd0, 32'd7);

`ifdef DIV_UNSIGNED_EN
    $display("[TB] unsigned divide");
    div_unsigned = 1'b1;
    divideCheck("u_ffff_p2", 32'hFFFF_FFFF, 32'd2, 32'h7FFF_FFFF, 32'd1);
    div_unsigned = 1'b0;
`endif

    $display("[TB] held start, back-to-back, operand change after E0");
    dividend  = 32'd100;
    divisor   = 32'd7;
    div_start = 1'b1;
    tick();
    dividend  = 32'd50;
    divisor   = 32'd5;
    waitDone(cycles);
    checkOutput("b2b_first_latency", cycles, 32'd33);
    checkOutput("b2b_first_lo", lo_out, 32'd14);
    checkOutput("b2b_first_hi", hi_out, 32'd2);
    tick();
    div_start = 1'b0;
    checkOutput("b2b_busy_restart", {31'd0, busy}, 32'd1);
    waitDone(cycles);
    checkOutput("b2b_second_latency", cycles, 32'd33);
    checkOutput("b2b_second_lo", lo_out, 32'd10);
    checkOutput("b2b_second_hi", hi_out, 32'd0);
    tick();

    $display("[TB] reset during run");
    applyStimulus(32'd1000, 32'd3);
    for (int i = 1; i < 10; i++) tick();
    dividend  = 32'd9;
    divisor   = 32'd0;
    div_start = 1'b1;
    tick();
    div_start = 1'b0;
    checkOutput("ignored_start_dz", {31'd0, div_zero}, 32'd0);
    checkOutput("ignored_start_busy", {31'd0, busy}, 32'd1);
    for (int i = 11; i < 20; i++) tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    checkOutput("midrun_rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("midrun_rst_done", {31'd0, done}, 32'd0);
    checkOutput("midrun_rst_dz", {31'd0, div_zero}, 32'd0);
    checkOutput("midrun_rst_hi", hi_out, 32'd0);
    checkOutput("midrun_rst_lo", lo_out, 32'd0);
    watchNoDone(40, seen);
    checkOutput("midrun_rst_no_done", {31'd0, seen}, 32'd0);
    divideCheck("restart_1000_3", 32'd1000, 32'd3, 32'd333, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
